// File: rtl/trigger_arb_pkg.sv
// rtl/trigger_arb_pkg.sv - shared control-plane trigger word types and round-robin helper
package trigger_arb_pkg;

  localparam int CP_ID_WIDTH        = 8;
  localparam int TRIGGER_ID_WIDTH   = 8;
  localparam int TRIGGER_WORD_WIDTH = CP_ID_WIDTH + TRIGGER_ID_WIDTH;

  typedef struct packed {
    logic [CP_ID_WIDTH-1:0]      cp_id;
    logic [TRIGGER_ID_WIDTH-1:0] trigger_id;
  } trigger_word_t;

  // Index following idx in a ring of n entries; n need not be a power of two.
  function automatic int rr_next(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/trigger_arb_fifo.sv
// rtl/trigger_arb_fifo.sv - first-word-fall-through event queue with occupancy count
module trigger_arb_fifo #(
  parameter int WIDTH       = 16,
  parameter int DEPTH_WIDTH = 3,
  parameter int DEPTH       = 2**DEPTH_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       rd_data,
  output logic                   full,
  output logic                   empty,
  output logic [DEPTH_WIDTH:0]   count,
  output logic [DEPTH_WIDTH:0]   count_next
);

  logic [WIDTH-1:0]       mem [DEPTH];
  logic [DEPTH_WIDTH-1:0] wr_ptr;
  logic [DEPTH_WIDTH-1:0] rd_ptr;
  logic                   do_push;
  logic                   do_pop;

  assign full    = (count == (DEPTH_WIDTH+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rd_data = mem[rd_ptr];

  // Occupancy after this edge; a simultaneous push and pop cancel out.
  always_comb begin
    count_next = count;
    if (do_push && !do_pop) count_next = count + 1'b1;
    if (!do_push && do_pop) count_next = count - 1'b1;
  end

  // Pointers and count; pointers wrap naturally because depth is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count_next;
    end
  end

  // Storage is deliberately left unreset; only pointers define valid contents.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/trigger_arb.sv
// rtl/trigger_arb.sv - round-robin trigger merge into one PRM event queue (optional stats: TRIGGER_ARB_STATS_EN)
module trigger_arb
  import trigger_arb_pkg::*;
#(
  parameter int NR_SRC           = 4,
  parameter int SRC_IDX_WIDTH    = 2,
  parameter int FIFO_DEPTH_WIDTH = 3,
  parameter int FIFO_DEPTH       = 2**FIFO_DEPTH_WIDTH
) (
  input  logic                               SYS_CLK,
  input  logic                               DETECT_RST,
  input  logic [NR_SRC-1:0]                  src_valid,
  input  logic [NR_SRC*TRIGGER_WORD_WIDTH-1:0] src_wdata,
  output logic [NR_SRC-1:0]                  src_ready,
  input  logic                               irq_en,
  output logic                               irq,
  input  logic                               pop,
  output logic [TRIGGER_WORD_WIDTH-1:0]      rd_data,
  output logic                               rd_empty,
  output logic [FIFO_DEPTH_WIDTH:0]          rd_count,
  output logic [SRC_IDX_WIDTH-1:0]           grant_src
`ifdef TRIGGER_ARB_STATS_EN
  ,
  input  logic [SRC_IDX_WIDTH-1:0]           stat_sel,
  input  logic                               stat_clr,
  output logic [31:0]                        stat_cnt
`endif
);

  logic [SRC_IDX_WIDTH-1:0]   rr_ptr;
  logic [SRC_IDX_WIDTH-1:0]   winner;
  logic                       any_valid;
  logic                       full;
  logic                       accept;
  logic [FIFO_DEPTH_WIDTH:0]  count_next;
  trigger_word_t              win_word;
  int                         idx;

  // Scan from rr_ptr downwards in priority so the lowest offset that is valid wins.
  always_comb begin
    winner    = rr_ptr;
    any_valid = 1'b0;
    idx       = 0;
    for (int k = NR_SRC - 1; k >= 0; k--) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NR_SRC) idx = idx - NR_SRC;
      if (src_valid[SRC_IDX_WIDTH'(idx)]) begin
        winner    = SRC_IDX_WIDTH'(idx);
        any_valid = 1'b1;
      end
    end
  end

  // Ready never depends on pop, so a full queue stalls sources even during a drain.
  assign accept   = any_valid & ~full & ~DETECT_RST;
  assign win_word = src_wdata[TRIGGER_WORD_WIDTH*winner +: TRIGGER_WORD_WIDTH];

  // One-hot ready toward the winning source only.
  always_comb begin
    src_ready = '0;
    if (accept) src_ready[winner] = 1'b1;
  end

  // Round-robin pointer and debug grant advance only on an accepted event.
  always_ff @(posedge SYS_CLK or posedge DETECT_RST) begin
    if (DETECT_RST) begin
      rr_ptr    <= '0;
      grant_src <= '0;
    end else if (accept) begin
      rr_ptr    <= SRC_IDX_WIDTH'(rr_next(int'(winner), NR_SRC));
      grant_src <= winner;
    end
  end

  // Level interrupt tracks the occupancy that will be present after this edge.
  always_ff @(posedge SYS_CLK or posedge DETECT_RST) begin
    if (DETECT_RST) irq <= 1'b0;
    else            irq <= irq_en & (count_next != '0);
  end

  trigger_arb_fifo #(
    .WIDTH       (TRIGGER_WORD_WIDTH),
    .DEPTH_WIDTH (FIFO_DEPTH_WIDTH),
    .DEPTH       (FIFO_DEPTH)
  ) u_fifo (
    .clk        (SYS_CLK),
    .rst        (DETECT_RST),
    .push       (accept),
    .push_data  (win_word),
    .pop        (pop),
    .rd_data    (rd_data),
    .full       (full),
    .empty      (rd_empty),
    .count      (rd_count),
    .count_next (count_next)
  );

`ifdef TRIGGER_ARB_STATS_EN
  logic [31:0] stat_q [NR_SRC];

  // Per-source accepted-event counters; a clear beats a same-cycle accept.
  always_ff @(posedge SYS_CLK or posedge DETECT_RST) begin
    if (DETECT_RST) begin
      for (int i = 0; i < NR_SRC; i++) stat_q[i] <= '0;
    end else if (stat_clr) begin
      for (int i = 0; i < NR_SRC; i++) stat_q[i] <= '0;
    end else if (accept) begin
      stat_q[winner] <= stat_q[winner] + 32'd1;
    end
  end

  assign stat_cnt = (int'(stat_sel) < NR_SRC) ? stat_q[stat_sel] : '0;
`endif

endmodule

// File: tb/tb_trigger_arb.sv
// tb/tb_trigger_arb.sv - table-driven and randomized checks of trigger_arb against a queue model
module tb_trigger_arb;

  localparam int NR    = 4;
  localparam int DW    = 3;
  localparam int DEPTH = 8;

  logic            SYS_CLK = 1'b0;
  logic            DETECT_RST;
  logic [NR-1:0]   src_valid;
  logic [NR*16-1:0] src_wdata;
  logic [NR-1:0]   src_ready;
  logic            irq_en;
  logic            irq;
  logic            pop;
  logic [15:0]     rd_data;
  logic            rd_empty;
  logic [DW:0]     rd_count;
  logic [1:0]      grant_src;
`ifdef TRIGGER_ARB_STATS_EN
  logic [1:0]      stat_sel;
  logic            stat_clr;
  logic [31:0]     stat_cnt;
`endif

  trigger_arb #(.NR_SRC(NR), .SRC_IDX_WIDTH(2), .FIFO_DEPTH_WIDTH(DW)) dut (
    .SYS_CLK    (SYS_CLK),
    .DETECT_RST (DETECT_RST),
    .src_valid  (src_valid),
    .src_wdata  (src_wdata),
    .src_ready  (src_ready),
    .irq_en     (irq_en),
    .irq        (irq),
    .pop        (pop),
    .rd_data    (rd_data),
    .rd_empty   (rd_empty),
    .rd_count   (rd_count),
    .grant_src  (grant_src)
`ifdef TRIGGER_ARB_STATS_EN
    ,
    .stat_sel   (stat_sel),
    .stat_clr   (stat_clr),
    .stat_cnt   (stat_cnt)
`endif
  );

  always #5 SYS_CLK = ~SYS_CLK;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a plain queue of words, a round-robin start index and per-source tallies.
  logic [15:0] mq[$];
  int          mrr;
  int          mgrant;
  bit          mirq;
  int unsigned mstat[NR];

  task automatic model_reset();
    mq.delete();
    mrr    = 0;
    mgrant = 0;
    mirq   = 0;
    for (int i = 0; i < NR; i++) mstat[i] = 0;
  endtask

  task automatic do_reset();
    src_valid  = '0;
    pop        = 1'b0;
    DETECT_RST = 1'b1;
    @(posedge SYS_CLK);
    #1;
    DETECT_RST = 1'b0;
    model_reset();
  endtask

  // One clock: drive at edge+1, check ready at the falling edge, check registers at next edge+1.
  task automatic cycle(input logic [NR-1:0] v, input logic p, input logic ie,
                       output logic [NR-1:0] got_ready, output int acc_idx);
    int          w;
    bit          acc;
    logic [15:0] word;
    logic [NR-1:0] exp_ready;
    src_valid = v;
    pop       = p;
    irq_en    = ie;
    w = -1;
    for (int k = 0; k < NR; k++) begin
      int i;
      i = (mrr + k) % NR;
      if (v[i] && w < 0) w = i;
    end
    acc       = (w >= 0) && (mq.size() < DEPTH);
    exp_ready = acc ? NR'(1 << w) : '0;
    word      = acc ? src_wdata[16*w +: 16] : 16'h0;
    #4;
    got_ready = src_ready;
    check("src_ready", src_ready, exp_ready);
    if (p && mq.size() > 0) void'(mq.pop_front());
    if (acc) begin
      mq.push_back(word);
      mrr    = (w + 1) % NR;
      mgrant = w;
    end
    mirq = ie && (mq.size() != 0);
`ifdef TRIGGER_ARB_STATS_EN
    if (stat_clr) for (int i = 0; i < NR; i++) mstat[i] = 0;
    else if (acc) mstat[w]++;
`endif
    acc_idx = acc ? w : -1;
    @(posedge SYS_CLK);
    #1;
    check("rd_count", rd_count, mq.size());
    check("rd_empty", rd_empty, mq.size() == 0);
    if (mq.size() > 0) check("rd_data", rd_data, mq[0]);
    check("irq", irq, mirq);
    check("grant_src", grant_src, mgrant);
  endtask

  typedef struct {
    bit            rst;
    logic [NR-1:0] valid;
    logic          pop;
    logic [NR-1:0] ready;
    int            count;
    logic [15:0]   head;
    logic          irq;
  } vec_t;

  vec_t          tbl[$];
  logic [NR-1:0] r;
  int            a;
  logic [15:0]   heads[8];
  logic [NR-1:0] pend_v;
  logic [15:0]   pend_d[NR];

  initial begin
    // Source i presents {i+1, 0x05}; source 2 therefore carries 0x0305.
    for (int i = 0; i < NR; i++) src_wdata[16*i +: 16] = {8'(i + 1), 8'h05};
    src_valid  = '0;
    pop        = 1'b0;
    irq_en     = 1'b1;
    DETECT_RST = 1'b1;
`ifdef TRIGGER_ARB_STATS_EN
    stat_sel = '0;
    stat_clr = 1'b0;
`endif
    #2;
    check("rst_count", rd_count, 0);
    check("rst_empty", rd_empty, 1);
    check("rst_irq", irq, 0);
    check("rst_grant", grant_src, 0);
    check("rst_ready", src_ready, 0);
    @(posedge SYS_CLK);
    #1;
    DETECT_RST = 1'b0;
    model_reset();

    // Single event, pop, empty pop, push after empty pop.
    tbl.push_back('{1, 4'b0100, 0, 4'b0100, 1, 16'h0305, 1});
    tbl.push_back('{0, 4'b0000, 1, 4'b0000, 0, 16'hxxxx, 0});
    tbl.push_back('{0, 4'b0000, 1, 4'b0000, 0, 16'hxxxx, 0});
    tbl.push_back('{0, 4'b0100, 0, 4'b0100, 1, 16'h0305, 1});
    // Round-robin fill from rr_ptr=0, then full behaviour.
    for (int k = 0; k < 8; k++)
      tbl.push_back('{k == 0, 4'b1111, 0, NR'(1 << (k % 4)), k + 1, 16'h0105, 1});
    tbl.push_back('{0, 4'b1111, 1, 4'b0000, 7, 16'h0205, 1});
    tbl.push_back('{0, 4'b1111, 0, 4'b0001, 8, 16'h0205, 1});
    heads = '{16'h0305, 16'h0405, 16'h0105, 16'h0205, 16'h0305, 16'h0405, 16'h0105, 16'hxxxx};
    for (int k = 0; k < 8; k++)
      tbl.push_back('{0, 4'b0000, 1, 4'b0000, 7 - k, heads[k], k != 7});
    // Empty pop, then push/pop at count 3 preserving order.
    tbl.push_back('{0, 4'b0000, 1, 4'b0000, 0, 16'hxxxx, 0});
    tbl.push_back('{0, 4'b0100, 0, 4'b0100, 1, 16'h0305, 1});
    tbl.push_back('{0, 4'b0001, 0, 4'b0001, 2, 16'h0305, 1});
    tbl.push_back('{0, 4'b0010, 0, 4'b0010, 3, 16'h0305, 1});
    tbl.push_back('{0, 4'b1000, 1, 4'b1000, 3, 16'h0105, 1});
    tbl.push_back('{0, 4'b0000, 1, 4'b0000, 2, 16'h0205, 1});
    tbl.push_back('{0, 4'b0000, 1, 4'b0000, 1, 16'h0405, 1});
    tbl.push_back('{0, 4'b0000, 1, 4'b0000, 0, 16'hxxxx, 0});

    foreach (tbl[n]) begin
      if (tbl[n].rst) do_reset();
      cycle(tbl[n].valid, tbl[n].pop, 1'b1, r, a);
      check($sformatf("tbl%0d_ready", n), r, tbl[n].ready);
      check($sformatf("tbl%0d_count", n), rd_count, tbl[n].count);
      check($sformatf("tbl%0d_empty", n), rd_empty, tbl[n].count == 0);
      if (tbl[n].count != 0) check($sformatf("tbl%0d_head", n), rd_data, tbl[n].head);
      check($sformatf("tbl%0d_irq", n), irq, tbl[n].irq);
    end

    // Randomized traffic: held-off sources keep valid and data stable until accepted.
    do_reset();
    pend_v = '0;
    for (int n = 0; n < 600; n++) begin
      for (int i = 0; i < NR; i++) begin
        if (!pend_v[i] && ($urandom_range(0, 2) == 0)) begin
          pend_v[i] = 1'b1;
          pend_d[i] = 16'($urandom);
        end
        src_wdata[16*i +: 16] = pend_d[i];
      end
`ifdef TRIGGER_ARB_STATS_EN
      stat_clr = ($urandom_range(0, 99) == 0);
`endif
      cycle(pend_v, 1'($urandom_range(0, 2) != 0 || n > 560), 1'($urandom_range(0, 9) != 0), r, a);
      if (a >= 0) pend_v[a] = 1'b0;
    end
`ifdef TRIGGER_ARB_STATS_EN
    stat_clr = 1'b0;
    for (int i = 0; i < NR; i++) begin
      stat_sel = 2'(i);
      #1;
      check($sformatf("stat_cnt%0d", i), stat_cnt, mstat[i]);
    end
`endif
    cycle('0, 1'b0, 1'b1, r, a);

    // Reset mid-burst at count 5 clears state asynchronously.
    do_reset();
    for (int i = 0; i < NR; i++) src_wdata[16*i +: 16] = 16'hA000 + 16'(i);
    for (int k = 0; k < 5; k++) cycle(4'b1111, 1'b0, 1'b1, r, a);
    check("burst_count", rd_count, 5);
    #2;
    DETECT_RST = 1'b1;
    #1;
    check("mid_rst_count", rd_count, 0);
    check("mid_rst_empty", rd_empty, 1);
    check("mid_rst_irq", irq, 0);
    check("mid_rst_ready", src_ready, 0);
`ifdef TRIGGER_ARB_STATS_EN
    for (int i = 0; i < NR; i++) begin
      stat_sel = 2'(i);
      #1;
      check($sformatf("mid_rst_stat%0d", i), stat_cnt, 0);
    end
`endif
    @(posedge SYS_CLK);
    #1;
    DETECT_RST = 1'b0;
    model_reset();
    cycle(4'b1111, 1'b0, 1'b1, r, a);
    check("post_rst_rr", r, 4'b0001);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/trigger_arb.md
Name: trigger_arb

Overview:
- Round-robin arbiter that merges trigger events from NR_SRC control-plane trigger tables into one buffered event queue.
- Sources are e.g. core, cache and memory CPs; each event is a 16-bit {CP_ID, trigger_id} word.
- Raises a level interrupt to the PRM while events are pending.
- The PRM drains the queue through a first-word-fall-through pop port.

Parameters:
- NR_SRC, 4: number of requesting trigger tables, 2..8.
- SRC_IDX_WIDTH, 2: clog2(NR_SRC), at least 1.
- FIFO_DEPTH_WIDTH, 3: log2 of queue depth (depth 8).
- FIFO_DEPTH, 2**FIFO_DEPTH_WIDTH: queue entries.

Ports:
- SYS_CLK, input, 1: clock.
- DETECT_RST, input, 1: asynchronous, active-high reset.
- src_valid, input, NR_SRC: per-source event valid (fifo_wvalid of each table).
- src_wdata, input, NR_SRC*16: packed event words; source i occupies [16*i+15:16*i].
- src_ready, output, NR_SRC: per-source accept, combinational.
- irq_en, input, 1: interrupt enable.
- irq, output, 1: pending-event interrupt, level.
- pop, input, 1: PRM dequeue strobe.
- rd_data, output, 16: queue head word.
- rd_empty, output, 1: queue empty.
- rd_count, output, FIFO_DEPTH_WIDTH+1: occupancy.
- grant_src, output, SRC_IDX_WIDTH: index of the last accepted source (debug).

Behaviour:
- Reset values: rr_ptr=0, queue rd/wr pointers=0, rd_count=0, rd_empty=1, irq=0, grant_src=0, src_ready=0. Queue storage is not reset.
- Arbitration is combinational:
  - Scan sources starting at rr_ptr, wrapping modulo NR_SRC.
  - The first source with src_valid=1 is the winner.
  - src_ready[i] = (i==winner) & any_valid & ~full. All other ready bits are 0.
- Accept occurs when src_valid[i] & src_ready[i]. On accept:
  - Write src_wdata slice i at wr_ptr; wr_ptr++ (wraps).
  - rr_ptr <= winner+1, modulo NR_SRC (NR_SRC need not be a power of 2).
  - grant_src <= winner.
- With no accept, rr_ptr is held. At most one event is accepted per cycle.
- Source behaviour: a source held off by ready=0 keeps valid asserted and holds its data stable (trigger tables stall on ~ready). The arbiter never drops an event.
- Fairness: a continuously valid source waits at most NR_SRC-1 accepts.
- full = (rd_count==FIFO_DEPTH). When full, every src_ready is 0, even if pop is asserted the same cycle. This keeps ready independent of pop.
- Pop and read:
  - rd_data = storage[rd_ptr] (FWFT); it is don't-care when empty.
  - pop & ~rd_empty: rd_ptr++ next cycle.
  - pop while empty: ignored, no pointer or count change.
- rd_count: +1 on accept only, -1 on valid pop only, unchanged when both occur. It saturates by construction: 0..FIFO_DEPTH.
- rd_empty = (rd_count==0).
- irq is registered: irq <= irq_en & (next rd_count != 0). It asserts 1 cycle after the first accept and deasserts 1 cycle after the pop that empties the queue.
- Latency: src_valid to rd_data/rd_empty visible = 1 cycle.
- DETECT_RST mid-operation: queue contents are lost; pointers, rr_ptr and irq are cleared immediately (async).

Optional Feature:
- Macro: TRIGGER_ARB_STATS_EN.
- When defined:
  - Adds input stat_sel [SRC_IDX_WIDTH-1:0] and output stat_cnt [31:0].
  - Keeps one 32-bit accepted-event counter per source. Each counter increments on that source's accept, wraps at 2^32, and resets to 0.
  - Adds input stat_clr (1); it zeroes all counters next cycle and has priority over a simultaneous increment.
  - stat_cnt = counter[stat_sel], combinational.
- When undefined: none of these ports or counters exist, and the behaviour is otherwise identical.

Decomposition:
- Shared control-plane package holds:
  - TRIGGER_WORD_WIDTH=16.
  - CP_ID field width 8 and trigger_id field width 8.
  - Helper function rr_next(idx, n).
- One natural sub-module: trigger_arb_fifo, a FWFT synchronous FIFO with push/pop/full/empty/count. It is parameterised by width and depth.
- Arbitration stays in the top module.

Test Plan:
- Single event: src_valid=4'b0100, word 0x0305 -> ready[2]=1 for 1 cycle; next cycle rd_data=0x0305, rd_empty=0, rd_count=1; irq=1 with irq_en=1. Pop -> rd_empty=1, and irq=0 one cycle later.
- Round-robin: all 4 sources valid for 8 cycles, rr_ptr=0 -> accept order 0,1,2,3,0,1,2,3 (stop after 8, queue full). Pop order matches.
- Full: 8 accepts with no pop -> rd_count=8, all src_ready=0. Pop+valid in the same cycle -> no accept, count=7. Next cycle -> accept, count=8.
- Empty pop: pop with rd_empty=1 -> rd_count stays 0, rd_ptr unchanged; then one push reads back correctly.
- Simultaneous push and pop at count=3 -> count stays 3; FIFO order preserved (4 pops return the oldest 3 then the new word).
- Reset mid-burst: DETECT_RST asserted at count=5 -> same cycle rd_count=0, irq=0, rr_ptr=0. With TRIGGER_ARB_STATS_EN defined, all stat_cnt read 0.
